// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that forwards host accesses onto a single-port register bus.
// It holds AW and W independently, lets reads wait with a timeout, and arbitrates fairly between reads and writes.
module axi_lite_reg_bridge #(
    parameter int C_DATA_WIDTH     = 32,
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_REG_ADDR_WIDTH = 10,
    parameter int C_RD_TIMEOUT     = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [C_REG_ADDR_WIDTH-1:0]   reg_addr,
    output logic                          reg_wr_en,
    output logic [C_DATA_WIDTH-1:0]       reg_wr_data,
    output logic [C_DATA_WIDTH/8-1:0]     reg_wr_strb,
    output logic                          reg_rd_en,
    input  logic [C_DATA_WIDTH-1:0]       reg_rd_data,
    input  logic                          reg_rd_vld,
    output logic                          reg_rd_ack,
    output logic [1:0]                    o_dbg_w_state,
    output logic [1:0]                    o_dbg_r_state
);

    localparam int STRB_W   = C_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int HI_LSB   = ADDR_LSB + C_REG_ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] TO_LAST     = 8'(C_RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_ISSUE   = 2'd1,
        W_RESP    = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAIT  = 2'd2,
        R_RESP  = 2'd3
    } r_state_t;

    w_state_t                      r_w_state, w_w_state_nx;
    r_state_t                      r_r_state, w_r_state_nx;

    logic                          r_rdy_en;
    logic                          r_aw_full, r_aw_oor, r_w_full;
    logic [C_REG_ADDR_WIDTH-1:0]   r_aw_addr;
    logic [C_DATA_WIDTH-1:0]       r_w_data;
    logic [STRB_W-1:0]             r_w_strb;
    logic [1:0]                    r_bresp;

    logic                          r_ar_full, r_ar_oor;
    logic [C_REG_ADDR_WIDTH-1:0]   r_ar_addr;
    logic [C_DATA_WIDTH-1:0]       r_rdata;
    logic [1:0]                    r_rresp;
    logic [7:0]                    r_to_cnt;
    logic                          r_rd_ack;
    logic                          r_prio_rd;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_wr_req, w_rd_req, w_wr_gnt, w_rd_gnt;
    logic w_rd_timeout;
    logic w_unused;

    // Only word-aligned register offsets matter; PROT and byte offset bits are dropped.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Valid/ready: a transfer occurs on a rising edge where both VALID and READY are 1;
    // VALID is never withdrawn by this slave until its handshake.
    assign S_AXI_AWREADY = r_rdy_en && (r_w_state == W_COLLECT) && !r_aw_full;
    assign S_AXI_WREADY  = r_rdy_en && (r_w_state == W_COLLECT) && !r_w_full;
    assign S_AXI_ARREADY = r_rdy_en && (r_r_state == R_IDLE) && !r_ar_full;
    assign S_AXI_BVALID  = (r_w_state == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = (r_r_state == R_RESP);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign w_b_hs  = S_AXI_BVALID && S_AXI_BREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_r_hs  = S_AXI_RVALID && S_AXI_RREADY;

    // Out-of-range accesses never request the register bus.
    assign w_wr_req = (r_w_state == W_ISSUE) && !r_aw_oor;
    assign w_rd_req = (r_r_state == R_ISSUE) && !r_ar_oor;
    assign w_rd_gnt = w_rd_req && (!w_wr_req || r_prio_rd);
    assign w_wr_gnt = w_wr_req && (!w_rd_req || !r_prio_rd);

    assign w_rd_timeout = (r_to_cnt == TO_LAST);

    assign reg_wr_en   = w_wr_gnt;
    assign reg_rd_en   = w_rd_gnt;
    assign reg_wr_data = w_wr_gnt ? r_w_data : '0;
    assign reg_wr_strb = w_wr_gnt ? r_w_strb : '0;
    assign reg_addr    = w_rd_gnt ? r_ar_addr : (w_wr_gnt ? r_aw_addr : '0);
    assign reg_rd_ack  = r_rd_ack;

    assign o_dbg_w_state = r_w_state;
    assign o_dbg_r_state = r_r_state;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rdy_en  <= 1'b0;
            r_prio_rd <= 1'b1;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_wr_req && w_rd_req) begin
                r_prio_rd <= ~r_prio_rd;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_w_state <= W_COLLECT;
            r_r_state <= R_IDLE;
        end else begin
            r_w_state <= w_w_state_nx;
            r_r_state <= w_r_state_nx;
        end
    end

    always_comb begin
        w_w_state_nx = r_w_state;
        case (r_w_state)
            W_COLLECT: if (r_aw_full && r_w_full)  w_w_state_nx = W_ISSUE;
            W_ISSUE:   if (r_aw_oor || w_wr_gnt)   w_w_state_nx = W_RESP;
            W_RESP:    if (S_AXI_BREADY)           w_w_state_nx = W_COLLECT;
            default:                               w_w_state_nx = W_COLLECT;
        endcase
    end

    always_comb begin
        w_r_state_nx = r_r_state;
        case (r_r_state)
            R_IDLE:  if (r_ar_full)                  w_r_state_nx = R_ISSUE;
            R_ISSUE: begin
                if (r_ar_oor)                        w_r_state_nx = R_RESP;
                else if (w_rd_gnt)                   w_r_state_nx = R_WAIT;
            end
            R_WAIT:  if (reg_rd_vld || w_rd_timeout) w_r_state_nx = R_RESP;
            R_RESP:  if (S_AXI_RREADY)               w_r_state_nx = R_IDLE;
            default:                                 w_r_state_nx = R_IDLE;
        endcase
    end

    // AW and W holders fill independently and drain together on the B handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_full <= 1'b0;
            r_aw_oor  <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_oor  <= |S_AXI_AWADDR[C_ADDR_WIDTH-1:HI_LSB];
                r_aw_addr <= S_AXI_AWADDR[HI_LSB-1:ADDR_LSB];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
            if (r_w_state == W_ISSUE) begin
                r_bresp <= r_aw_oor ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_b_hs) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_ar_full <= 1'b0;
            r_ar_oor  <= 1'b0;
            r_ar_addr <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_to_cnt  <= '0;
            r_rd_ack  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_ar_full <= 1'b1;
                r_ar_oor  <= |S_AXI_ARADDR[C_ADDR_WIDTH-1:HI_LSB];
                r_ar_addr <= S_AXI_ARADDR[HI_LSB-1:ADDR_LSB];
            end
            case (r_r_state)
                R_ISSUE: begin
                    r_to_cnt <= '0;
                    if (r_ar_oor) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end
                end
                R_WAIT: begin
                    r_to_cnt <= r_to_cnt + 8'd1;
                    if (reg_rd_vld) begin
                        r_rdata <= reg_rd_data;
                        r_rresp <= RESP_OKAY;
                    end else if (w_rd_timeout) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end
                end
                default: ;
            endcase
            if (w_r_hs) begin
                r_ar_full <= 1'b0;
            end
            // Acknowledge only reads whose data actually came from the register bus.
            r_rd_ack <= w_r_hs && (r_rresp == RESP_OKAY);
        end
    end

endmodule
